ifu_fetch: RTL and testbench

Instruction fetch unit that produces the inst/pc pair consumed by the RV32E decode stage. It is the producer end of the fetch-to-decode interface.
- Owns the architectural fetch PC.
- Issues one instruction-memory read at a time over a valid/ready request and valid response port.
- Presents each fetched word to decode with a valid/ready handshake.
- Accepts redirects from execute for branch, jal, jalr, ecall, mret and trap.

---
 rtl/ifu_pkg.sv | 15 +
 rtl/ifu_fetch.sv | 113 +++++++++++
 tb/tb_ifu_fetch.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared types and constants for the instruction fetch unit
package ifu_pkg;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        HOLD,
        FAULT
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] INST_BYTES       = 32'd4;

endpackage

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch unit producing inst/pc for the RV32E decode stage
// One memory read in flight at most; redirects from execute take priority over everything.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = ifu_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INST = ifu_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        imem_resp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        fetch_fault,
    output logic [31:0] fault_pc
);
    import ifu_pkg::*;

    fetch_state_t state;
    logic [31:0]  fetch_pc;
    logic         drop;
    logic         req_fire;
    logic         redirect_misaligned;
    logic         outstanding;

    assign imem_req_valid      = (state == REQ) && !halt && !rst;
    assign imem_req_addr       = fetch_pc;
    assign req_fire            = imem_req_valid && imem_req_ready;
    assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);

    // A request is still owed a response after this edge: just accepted, waiting
    // without the response arriving now, or a stale one pending while faulted.
    assign outstanding = req_fire
                      || ((state == WAIT) && !imem_resp_valid)
                      || ((state == FAULT) && drop && !imem_resp_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= REQ;
            fetch_pc    <= RESET_PC;
            drop        <= 1'b0;
            inst_valid  <= 1'b0;
            inst        <= NOP_INST;
            pc          <= RESET_PC;
            fetch_fault <= 1'b0;
            fault_pc    <= '0;
        end else if (redirect_valid) begin
            inst_valid <= 1'b0;
            inst       <= NOP_INST;
            drop       <= outstanding;
            if (redirect_misaligned) begin
                state       <= FAULT;
                fetch_fault <= 1'b1;
                fault_pc    <= redirect_pc;
            end else begin
                fetch_pc    <= redirect_pc;
                fetch_fault <= 1'b0;
                state       <= outstanding ? WAIT : REQ;
            end
        end else begin
            case (state)
                REQ: begin
                    if (req_fire) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_resp_valid) begin
                        if (drop) begin
                            drop  <= 1'b0;
                            state <= REQ;
                        end else if (imem_resp_err) begin
                            state       <= FAULT;
                            fetch_fault <= 1'b1;
                            fault_pc    <= fetch_pc;
                        end else begin
                            inst       <= imem_resp_data;
                            pc         <= fetch_pc;
                            inst_valid <= 1'b1;
                            state      <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (inst_ready) begin
                        fetch_pc   <= fetch_pc + INST_BYTES;
                        inst_valid <= 1'b0;
                        inst       <= NOP_INST;
                        state      <= REQ;
                    end
                end
                FAULT: begin
                    // The stale response owed to a dropped request retires here.
                    if (imem_resp_valid) begin
                        drop <= 1'b0;
                    end
                end
                default: begin
                    state <= FAULT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - self-checking bench for ifu_fetch with a transaction-level fetch model
module tb_ifu_fetch;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        imem_resp_err = 1'b0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic        fetch_fault;
    logic [31:0] fault_pc;

    ifu_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .imem_resp_err  (imem_resp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .pc             (pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .fetch_fault    (fetch_fault),
        .fault_pc       (fault_pc)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: what is in flight, what decode should be holding, where fetch goes next.
    bit          inflight = 0;
    bit          in_stale = 0;
    int          in_delay = 0;
    logic [31:0] in_addr = '0;
    bit          held = 0;
    logic [31:0] held_pc = '0;
    logic [31:0] held_inst = '0;
    logic [31:0] exp_fetch = RST_PC;
    bit          exp_fault = 0;
    logic [31:0] exp_fault_pc = '0;
    int          lat = 0;
    logic [31:0] err_addr = 32'h0000_0001;
    bit          saw_dead = 0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0010_0093;
        if (a == 32'h8000_0008) return 32'hDEAD_BEEF;
        return a ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
            chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
            chk("rst_inst", inst, NOP);
            chk("rst_pc", pc, RST_PC);
            chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
            chk("rst_fault_pc", fault_pc, 32'd0);
        end else begin
            chk("req_valid", {31'b0, imem_req_valid},
                {31'b0, (!exp_fault && !held && !inflight && !halt)});
            if (!exp_fault && !held && !inflight && !halt)
                chk("req_addr", imem_req_addr, exp_fetch);
            chk("inst_valid", {31'b0, inst_valid}, {31'b0, held});
            if (held) begin
                chk("inst", inst, held_inst);
                chk("pc", pc, held_pc);
            end else begin
                chk("inst_nop", inst, NOP);
            end
            chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, exp_fault});
            chk("fault_pc", fault_pc, exp_fault_pc);
            if (inst_valid && inst == 32'hDEAD_BEEF) saw_dead = 1;
        end
    end

    // One clock: drive inputs for the coming edge and advance the model across it.
    task automatic step(input bit rdy = 1'b1, input bit rdv = 1'b0,
                        input logic [31:0] rpc = 32'h0, input bit hlt = 1'b0,
                        input bit mrdy = 1'b1, input bit pulse = 1'b0);
        bit resp;
        bit acc;
        bit hand;
        @(negedge clk);
        #1;
        rst  = 1'b0;
        resp = inflight && (in_delay == 0);
        acc  = !exp_fault && !held && !inflight && !hlt && mrdy;
        hand = held && rdy && !rdv;
        imem_resp_valid = resp || pulse;
        imem_resp_data  = resp ? word_of(in_addr) : 32'hDEAD_BEEF;
        imem_resp_err   = resp && (in_addr == err_addr);
        inst_ready      = rdy;
        redirect_valid  = rdv;
        redirect_pc     = rpc;
        halt            = hlt;
        imem_req_ready  = mrdy;
        if (hand) begin
            held      = 0;
            exp_fetch = held_pc + 32'd4;
        end
        if (resp) begin
            inflight = 0;
            if (!in_stale && !rdv) begin
                if (in_addr == err_addr) begin
                    exp_fault    = 1;
                    exp_fault_pc = in_addr;
                end else begin
                    held      = 1;
                    held_pc   = in_addr;
                    held_inst = word_of(in_addr);
                end
            end
        end else if (inflight) begin
            in_delay--;
        end
        if (acc) begin
            inflight = 1;
            in_addr  = exp_fetch;
            in_stale = 0;
            in_delay = lat;
        end
        if (rdv) begin
            held = 0;
            if (inflight) in_stale = 1;
            if (rpc[1:0] != 2'b00) begin
                exp_fault    = 1;
                exp_fault_pc = rpc;
            end else begin
                exp_fetch = rpc;
                exp_fault = 0;
            end
        end
        #1;
    endtask

    task automatic do_reset(input int n, input bit late);
        @(negedge clk);
        #1;
        rst = 1'b1;
        inst_ready = 0; redirect_valid = 0; halt = 0; imem_req_ready = 1;
        imem_resp_valid = 0; imem_resp_err = 0;
        inflight = 0; held = 0; exp_fault = 0; exp_fault_pc = '0; exp_fetch = RST_PC;
        #1;
        chk("async_rst_iv", {31'b0, inst_valid}, 32'd0);
        chk("async_rst_inst", inst, NOP);
        chk("async_rst_pc", pc, RST_PC);
        chk("async_rst_req", {31'b0, imem_req_valid}, 32'd0);
        repeat (n) begin
            @(negedge clk);
            #1;
            imem_resp_valid = late;
            imem_resp_data  = 32'hDEAD_BEEF;
        end
    endtask

    task automatic wait_iv(input string name);
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (inst_valid) begin
                ok = 1;
                break;
            end
            step(.rdy(1'b0));
        end
        chk(name, {31'b0, ok}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);

        // First fetch from reset with zero-wait memory.
        step();
        step();
        chk("t1_wait_iv", {31'b0, inst_valid}, 32'd0);
        step(.rdy(1'b1));
        chk("t1_iv", {31'b0, inst_valid}, 32'd1);
        chk("t1_pc", pc, 32'h8000_0000);
        chk("t1_inst", inst, 32'h0010_0093);
        step();
        chk("t1_next_req", {31'b0, imem_req_valid}, 32'd1);
        chk("t1_next_addr", imem_req_addr, 32'h8000_0004);

        // Decode stalls for 5 cycles.
        repeat (6) step(.rdy(1'b0));
        chk("t2_iv", {31'b0, inst_valid}, 32'd1);
        chk("t2_pc", pc, 32'h8000_0004);
        chk("t2_inst", inst, 32'h9234_567C);
        chk("t2_no_req", {31'b0, imem_req_valid}, 32'd0);
        step(.rdy(1'b1));
        step(.rdy(1'b0), .mrdy(1'b0));
        chk("t2_req", {31'b0, imem_req_valid}, 32'd1);
        chk("t2_addr", imem_req_addr, 32'h8000_0008);

        // Redirect while waiting; the stale DEADBEEF response must be discarded.
        lat = 1;
        step();
        step(.rdv(1'b1), .rpc(32'h8000_0100));
        step();
        step(.mrdy(1'b0));
        chk("t3_req", {31'b0, imem_req_valid}, 32'd1);
        chk("t3_addr", imem_req_addr, 32'h8000_0100);
        lat = 0;
        repeat (4) step();

        // Misaligned redirect faults; an aligned one recovers.
        step(.rdv(1'b1), .rpc(32'h8000_0202));
        repeat (3) step();
        chk("t4_fault", {31'b0, fetch_fault}, 32'd1);
        chk("t4_fault_pc", fault_pc, 32'h8000_0202);
        chk("t4_no_req", {31'b0, imem_req_valid}, 32'd0);
        step(.rdv(1'b1), .rpc(32'h8000_0000));
        step(.rdy(1'b0));
        chk("t4_cleared", {31'b0, fetch_fault}, 32'd0);
        wait_iv("t4_refetch_timeout");
        chk("t4_pc", pc, 32'h8000_0000);
        chk("t4_inst", inst, 32'h0010_0093);

        // Access fault on 0x80000008.
        err_addr = 32'h8000_0008;
        begin
            bit got = 0;
            for (int i = 0; i < 30; i++) begin
                if (fetch_fault) begin
                    got = 1;
                    break;
                end
                step();
            end
            chk("t5_fault_timeout", {31'b0, got}, 32'd1);
        end
        chk("t5_fault_pc", fault_pc, 32'h8000_0008);
        chk("t5_iv", {31'b0, inst_valid}, 32'd0);
        err_addr = 32'h0000_0001;

        // Halt blocks requests; redirect in HOLD beats inst_ready.
        step(.rdv(1'b1), .rpc(32'h8000_0020));
        step(.hlt(1'b1));
        chk("t6_halt_req", {31'b0, imem_req_valid}, 32'd0);
        repeat (2) step(.hlt(1'b1), .mrdy(1'b0));
        step();
        wait_iv("t6_resume_timeout");
        chk("t6_pc", pc, 32'h8000_0020);
        step(.rdy(1'b1), .rdv(1'b1), .rpc(32'h8000_0040));
        step(.mrdy(1'b0));
        chk("t6_redir_addr", imem_req_addr, 32'h8000_0040);
        chk("t6_redir_iv", {31'b0, inst_valid}, 32'd0);

        // Address wrap at the top of memory; retracted request in REQ.
        step(.rdv(1'b1), .rpc(32'hFFFF_FFFC), .mrdy(1'b0));
        wait_iv("t7_wrap_timeout");
        chk("t7_pc", pc, 32'hFFFF_FFFC);
        step(.rdy(1'b1));
        step(.mrdy(1'b0));
        chk("t7_wrap_addr", imem_req_addr, 32'h0000_0000);

        // Reset during WAIT with a late response pulse.
        step(.rdv(1'b1), .rpc(32'h8000_0010), .mrdy(1'b0));
        lat = 3;
        step();
        step();
        do_reset(2, 1'b1);
        lat = 0;
        step(.pulse(1'b1));
        step();
        chk("t8_wait_iv", {31'b0, inst_valid}, 32'd0);
        step(.rdy(1'b0));
        chk("t8_iv", {31'b0, inst_valid}, 32'd1);
        chk("t8_pc", pc, 32'h8000_0000);
        chk("t8_inst", inst, 32'h0010_0093);
        repeat (4) step();

        chk("never_deadbeef", {31'b0, saw_dead}, 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
